// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared types and constants for the shared-memory bus arbiter.
//            Holds the arbiter state enum, the index-width helper and the
//            default widths used by mem_arbiter and rr_pick.
// Revision : 1.0  initial release
// ============================================================================
package arb_pkg;

    localparam int c_DEF_NUM_CH   = 3;
    localparam int c_DEF_ADDR_W   = 8;
    localparam int c_DEF_DATA_W   = 32;
    localparam int c_DEF_HOLD_MAX = 16;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arbState_t;

    // Bits needed to hold an index 0..n-1; never less than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotate-priority encoder. Returns the first set
//            request bit found scanning upward from ptr, wrapping at NUM_CH-1.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_CH = 3,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    // One spare bit so ptr+offset never overflows before the wrap compare.
    logic [IDX_W:0] w_sum;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_sum = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(NUM_CH)) begin
                w_sum = w_sum - (IDX_W + 1)'(NUM_CH);
            end
            if (req[w_sum[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = w_sum[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : N-channel round-robin arbiter for the shared-memory bus. Grants
//            held, exclusive ownership so a client can finish an atomic
//            read-modify-write, and muxes the owner's address, write data and
//            write strobe onto the memory port.
//            Optional macro ARB_TIMEOUT_EN bounds a grant to HOLD_MAX cycles
//            and pulses preempt on the revoked channel.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_CH   = c_DEF_NUM_CH,
    parameter int ADDR_W   = c_DEF_ADDR_W,
    parameter int DATA_W   = c_DEF_DATA_W,
    parameter int HOLD_MAX = c_DEF_HOLD_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    output logic [NUM_CH-1:0]        grant,
    input  logic [NUM_CH*ADDR_W-1:0] addr_in,
    input  logic [NUM_CH*DATA_W-1:0] wdata_in,
    input  logic [NUM_CH-1:0]        rw_in,
    output logic                     mem_en,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_rw,
    output logic                     busy,
    output logic [NUM_CH-1:0]        preempt
);

    localparam int                 c_IDX_W = idxWidth(NUM_CH);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NUM_CH - 1);

    if (NUM_CH < 2 || NUM_CH > 16 || HOLD_MAX < 1) begin : g_paramCheck
        $error("mem_arbiter: NUM_CH must be 2..16 and HOLD_MAX at least 1");
    end

    arbState_t           r_state;
    arbState_t           w_nextState;
    logic [c_IDX_W-1:0]  r_owner;
    logic [c_IDX_W-1:0]  r_ptr;
    logic [c_IDX_W-1:0]  w_pickIdx;
    logic [c_IDX_W-1:0]  w_nextPtr;
    logic                w_pickFound;
    logic                w_ownerReq;
    logic                w_timeout;
    logic                w_release;
    logic [NUM_CH-1:0]   r_grant;
    logic [NUM_CH-1:0]   r_preempt;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (c_IDX_W)
    ) u_rrPick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_pickFound),
        .idx   (w_pickIdx)
    );

    assign w_ownerReq = req[r_owner];
    // Explicit wrap so non-power-of-two channel counts rotate correctly.
    assign w_nextPtr  = (r_owner == c_LAST) ? '0 : r_owner + 1'b1;

`ifdef ARB_TIMEOUT_EN
    localparam int c_CNT_W = idxWidth(HOLD_MAX + 1);
    logic [c_CNT_W-1:0] r_holdCnt;

    assign w_timeout = (r_holdCnt == c_CNT_W'(HOLD_MAX)) && w_ownerReq;

    // Count granted cycles; reads 1 in the first granted cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_holdCnt <= '0;
        end else if (r_state == ARB_IDLE) begin
            r_holdCnt <= c_CNT_W'(1);
        end else if (!w_release) begin
            r_holdCnt <= r_holdCnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_release = (r_state == ARB_GRANT) && (!w_ownerReq || w_timeout);

    // State, owner, rotation pointer and registered grant/preempt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_preempt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_preempt <= '0;
            if (r_state == ARB_IDLE && w_pickFound) begin
                r_owner <= w_pickIdx;
                r_grant <= NUM_CH'(1) << w_pickIdx;
            end else if (w_release) begin
                r_grant <= '0;
                r_ptr   <= w_nextPtr;
                if (w_timeout) begin
                    r_preempt <= NUM_CH'(1) << r_owner;
                end
            end
        end
    end

    // Next state: claim on any request, give up on owner release or timeout.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ARB_IDLE:  if (w_pickFound) w_nextState = ARB_GRANT;
            ARB_GRANT: if (w_release)   w_nextState = ARB_IDLE;
            default:   w_nextState = ARB_IDLE;
        endcase
    end

    // Memory port mux driven from the registered owner; zero when unowned.
    always_comb begin
        busy      = (r_state == ARB_GRANT);
        mem_en    = |r_grant;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rw    = 1'b0;
        if (mem_en) begin
            mem_addr  = addr_in[int'(r_owner) * ADDR_W +: ADDR_W];
            mem_wdata = wdata_in[int'(r_owner) * DATA_W +: DATA_W];
            mem_rw    = rw_in[r_owner];
        end
    end

    assign grant   = r_grant;
    assign preempt = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed scenarios followed
//            by randomized requests, checked against a behavioural model.
//            Build with ARB_TIMEOUT_EN defined to exercise the timeout path.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int HM = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    rwIn = '0;
    logic [N*AW-1:0] addrIn = '0;
    logic [N*DW-1:0] wdataIn = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    preempt;
    logic            memEn;
    logic            memRw;
    logic            busy;
    logic [AW-1:0]   memAddr;
    logic [DW-1:0]   memWdata;

    mem_arbiter #(
        .NUM_CH   (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .HOLD_MAX (HM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant     (grant),
        .addr_in   (addrIn),
        .wdata_in  (wdataIn),
        .rw_in     (rwIn),
        .mem_en    (memEn),
        .mem_addr  (memAddr),
        .mem_wdata (memWdata),
        .mem_rw    (memRw),
        .busy      (busy),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: owner (-1 = none), rotation start, hold length, preempt.
    int mOwn  = -1;
    int mPtr  = 0;
    int mHold = 0;
    int mPre  = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oneHot(input int i);
        return (i < 0) ? '0 : (N'(1) << i);
    endfunction

    task automatic modelReset();
        mOwn  = -1;
        mPtr  = 0;
        mHold = 0;
        mPre  = -1;
    endtask

    // One clock edge of the arbitration rules, using the requests seen at the edge.
    task automatic modelStep();
        if (rst) begin
            modelReset();
            return;
        end
        mPre = -1;
        if (mOwn < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (mPtr + k) % N;
                if (req[c]) begin
                    mOwn  = c;
                    mHold = 1;
                    break;
                end
            end
        end else if (!req[mOwn] || (TO && mHold == HM)) begin
            if (req[mOwn]) mPre = mOwn;
            mPtr = (mOwn + 1) % N;
            mOwn = -1;
        end else begin
            mHold++;
        end
    endtask

    task automatic checkOutputs(input string tag);
        logic [AW-1:0] eA;
        logic [DW-1:0] eD;
        logic          eR;
        eA = '0;
        eD = '0;
        eR = 1'b0;
        if (mOwn >= 0) begin
            eA = addrIn[mOwn*AW +: AW];
            eD = wdataIn[mOwn*DW +: DW];
            eR = rwIn[mOwn];
        end
        chk({tag, ".grant"},   grant,    oneHot(mOwn));
        chk({tag, ".busy"},    busy,     (mOwn >= 0));
        chk({tag, ".memEn"},   memEn,    (mOwn >= 0));
        chk({tag, ".memAddr"}, memAddr,  eA);
        chk({tag, ".memWdat"}, memWdata, eD);
        chk({tag, ".memRw"},   memRw,    eR);
        chk({tag, ".preempt"}, preempt,  oneHot(mPre));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutputs(tag);
    endtask

    task automatic randData();
        for (int c = 0; c < N; c++) begin
            addrIn[c*AW +: AW]  = AW'($urandom);
            wdataIn[c*DW +: DW] = $urandom;
            rwIn[c]             = 1'($urandom);
        end
    endtask

    // Called at a falling edge; leaves reset released at a falling edge.
    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkOutputs("reset");
        tick("resetHold");
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int otherG;
        int ch2G;
        int held;
        int directSwitch;
        logic [N-1:0] prevG;
        logic [N-1:0] order[$];

        @(negedge clk);
        modelReset();
        checkOutputs("reset");
        rst = 1'b0;

        // Single request on ch1 two cycles after reset
        tick("idle");
        tick("idle");
        addrIn[1*AW +: AW] = 8'h05;
        req = 3'b010;
        tick("single");
        chk("single.grantConst", grant, 3'b010);
        chk("single.addrConst", memAddr, 8'h05);

        // Atomic hold: ch1 keeps ownership while ch0/ch2 also request
        otherG = 0;
        for (int c = 0; c < 10; c++) begin
            req  = 3'b111;
            rwIn = (c >= 8) ? 3'b111 : 3'b101;
            wdataIn = {$urandom, $urandom, $urandom};
            tick("atomic");
            if ((grant & 3'b101) != 3'b000) otherG++;
        end
        chk("atomic.otherGrants", otherG, 0);
        chk("atomic.rwOwner", memRw, 1'b1);
        req = 3'b101;
        tick("atomicRel");
        chk("atomic.deadCycle", grant, 3'b000);
        tick("atomicNext");
        chk("atomic.nextIsCh2", grant, 3'b100);
        req = 3'b000;
        tick("quiet");
        tick("quiet");

        // Release/skip: ch2 requests then withdraws while ch0 owns
        doReset();
        ch2G = 0;
        req = 3'b001; tick("skip"); if (grant[2]) ch2G++;
        req = 3'b101; tick("skip"); if (grant[2]) ch2G++;
        tick("skip"); if (grant[2]) ch2G++;
        req = 3'b001; tick("skip"); if (grant[2]) ch2G++;
        req = 3'b000; tick("skip"); if (grant[2]) ch2G++;
        tick("skip"); if (grant[2]) ch2G++;
        chk("skip.ch2Never", ch2G, 0);
        req = 3'b101;
        tick("skipPtr");
        chk("skip.ptrPastOwner", grant, 3'b100);
        req = 3'b000;
        tick("quiet");
        tick("quiet");

        // Reset during ch0 ownership
        req = 3'b001;
        tick("preRst");
        tick("preRst");
        rst = 1'b1;
        #1;
        modelReset();
        chk("rstMid.grant", grant, 3'b000);
        chk("rstMid.memEn", memEn, 1'b0);
        checkOutputs("rstMid");
        tick("rstMidHold");
        rst = 1'b0;
        req = 3'b110;
        tick("postRst");
        chk("postRst.ch1First", grant, 3'b010);
        req = 3'b000;
        tick("quiet");
        tick("quiet");

        // Round-robin: everyone requests, each owner drops after 4 cycles
        doReset();
        prevG = '0;
        directSwitch = 0;
        for (int c = 0; c < 40; c++) begin
            req = (mOwn >= 0 && mHold >= 4) ? ~oneHot(mOwn) : 3'b111;
            tick("rr");
            if (grant != '0 && grant != prevG) order.push_back(grant);
            if (prevG != '0 && grant != '0 && grant != prevG) directSwitch++;
            prevG = grant;
        end
        chk("rr.enoughGrants", (order.size() >= 4), 1'b1);
        if (order.size() >= 4) begin
            chk("rr.order0", order[0], 3'b001);
            chk("rr.order1", order[1], 3'b010);
            chk("rr.order2", order[2], 3'b100);
            chk("rr.order3", order[3], 3'b001);
        end
        chk("rr.deadCycle", directSwitch, 0);
        req = 3'b000;
        tick("quiet");
        tick("quiet");

        // Long hold by ch0 with ch1 waiting
        doReset();
        req = 3'b011;
        tick("hold");
`ifdef ARB_TIMEOUT_EN
        held = 0;
        while (grant == 3'b001 && held < 40) begin
            held++;
            tick("timeout");
        end
        chk("timeout.heldCycles", held, HM);
        chk("timeout.preempt", preempt, 3'b001);
        chk("timeout.grantOff", grant, 3'b000);
        tick("timeoutNext");
        chk("timeout.ch1Granted", grant, 3'b010);
        chk("timeout.preemptOnce", preempt, 3'b000);
`else
        held = 0;
        for (int c = 0; c < 25; c++) begin
            tick("unbounded");
            if (grant == 3'b001) held++;
        end
        chk("unbounded.heldCycles", held, 25);
        chk("unbounded.noPreempt", preempt, 3'b000);
`endif
        req = 3'b000;
        tick("quiet");
        tick("quiet");

        // Randomized traffic
        doReset();
        for (int c = 0; c < 400; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (req[ch]) begin
                    if ($urandom_range(0, 7) == 0) req[ch] = 1'b0;
                end else begin
                    if ($urandom_range(0, 3) == 0) req[ch] = 1'b1;
                end
            end
            randData();
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-channel round-robin arbiter for the shared-memory bus. It grants exclusive, held ownership to one requester at a time. This lets a client complete atomic read-modify-write sequences without interruption. It muxes the owner's address, write data and read/write strobe onto the single memory port. It sits between the memory clients (readers, atomic incrementers) and the shared memory, replacing the fixed 3-channel controller.

## Interface
- `NUM_CH`, 3, number of requesting channels (2..16)
- `ADDR_W`, 8, memory address width
- `DATA_W`, 32, memory data width
- `HOLD_MAX`, 16, maximum cycles one grant may be held (used only with timeout feature)

- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: asynchronous, active-high reset
- `req` in NUM_CH: per-channel request; held high for as long as ownership is wanted
- `grant` out NUM_CH: one-hot (or zero) ownership, registered
- `addr_in` in NUM_CH*ADDR_W: channel i address at `[i*ADDR_W +: ADDR_W]`
- `wdata_in` in NUM_CH*DATA_W: channel i write data at `[i*DATA_W +: DATA_W]`
- `rw_in` in NUM_CH: channel i write strobe (1 = write, 0 = read)
- `mem_en` out 1: memory enable, equals OR of `grant`
- `mem_addr` out ADDR_W: owner's address; 0 when no owner
- `mem_wdata` out DATA_W: owner's write data; 0 when no owner
- `mem_rw` out 1: owner's write strobe; 0 when no owner
- `busy` out 1: high in GRANT state
- `preempt` out NUM_CH: one-cycle pulse on the channel whose grant was revoked by timeout

## Operation
- States are IDLE and GRANT. Registered state includes `owner` index, `ptr` (round-robin start index) and, with the timeout feature, `hold_cnt`.
- IDLE: if any `req` is high, select the first set bit scanning from `ptr` upward with wrap (ptr, ptr+1, …, NUM_CH-1, 0, …). Set `owner` and `grant[owner]`, then go to GRANT. If no `req` is high, stay in IDLE.
- GRANT: hold while `req[owner]` is high. When `req[owner]` is seen low, clear `grant`, set `ptr = owner+1` (wrap to 0 at NUM_CH), and go to IDLE.
- Requests from other channels during GRANT are not acted on; they wait. Requests are level-based; a requester that drops `req` before being granted is simply skipped.
- The memory mux is combinational from the registered `owner`/`grant`. Memory read data is routed directly to clients outside this block.
- Reset: `grant`=0, `preempt`=0, `busy`=0, `mem_*`=0, `ptr`=0, `owner`=0, state IDLE. Reset asserted mid-grant drops ownership immediately; no completion of the client's sequence is guaranteed.
- Arithmetic: `ptr`/`owner` are $clog2(NUM_CH) bits. Wrap is an explicit compare to NUM_CH-1, not a power-of-two overflow.

## Timing
- Grant latency: `req` high in cycle 0 while in IDLE → `grant` high from cycle 1.
- Release: `req[owner]` low in cycle k → `grant` low from cycle k+1. The earliest next grant is cycle k+2, so there is always one dead cycle between owners.
- Fairness: with all channels requesting continuously and each holding for H cycles, channels are served in ascending cyclic order. The worst-case wait is (NUM_CH-1)*(H+2) cycles.
- No combinational path from `req` to `grant`. There is a combinational path from `addr_in`/`wdata_in`/`rw_in` to `mem_*`.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - `hold_cnt` counts cycles in GRANT, starting from 1 in the first granted cycle.
  - When `hold_cnt == HOLD_MAX` and `req[owner]` is still high, the arbiter clears `grant` on the next edge and pulses `preempt[owner]` for that cycle.
  - It then sets `ptr = owner+1` and goes to IDLE.
  - A preempted channel keeping `req` high is re-arbitrated normally.
- `ARB_TIMEOUT_EN` undefined: there is no counter, `preempt` is tied to 0, and `HOLD_MAX` is ignored. Ownership is unbounded.

## Structure
- Package `arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_GRANT`);
  - the index-width localparam helper;
  - the default-width constants.
- Sub-module `rr_pick`: a combinational rotate-priority encoder. Inputs are `req` and `ptr`. Outputs are `found` and `idx`. It is instantiated once.

## Test plan
- Single request: after reset, `req`=3'b010 at cycle 2 → `grant`=3'b010 at cycle 3. `mem_addr` equals `addr_in` channel 1 (e.g. 8'h05) while granted.
- Round-robin: all three `req` high continuously, each channel dropping its `req` 4 cycles after its grant → grant order ch0, ch1, ch2, ch0, with exactly one zero-grant cycle between owners.
- Atomic hold: ch1 holds for 10 cycles doing read then write (`rw_in`=1 at cycle 9) while ch0 and ch2 request → no other grant appears. `mem_rw`=1 only when ch1 drives it.
- Release/skip: ch2 requests then drops before it is granted → ch2 is never granted, and `ptr` advances past the prior owner only.
- Reset mid-grant: assert `rst` during ch0 ownership → `grant`=0 and `mem_en`=0 immediately. After deassert with `req`=3'b110, ch1 is granted first (`ptr`=0, scanning upward).
- Timeout (`ARB_TIMEOUT_EN`, `HOLD_MAX`=16): ch0 holds `req` indefinitely and ch1 requests → `grant[0]` drops after 16 granted cycles, `preempt`=3'b001 for one cycle, and ch1 is granted two cycles later.
